// File: rtl/pred_pkg.sv
// Shared constants and types for the fetch-stage branch predictor.
// Counter encoding: SNT=00, WNT=01, WT=10, ST=11 (MSB is the taken prediction).
package pred_pkg;

    localparam int IDX_W = 8;              // index bits, BHT and BTB depth = 2**IDX_W
    localparam int GHR_W = 8;              // global history width, equal to IDX_W
    localparam int TAG_W = 20;             // BTB tag = pc[31:12]
    localparam int N_ENT = 1 << IDX_W;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_t;

    // Saturating 2-bit update: step toward taken or not-taken, clamped at the ends.
    function automatic cnt_t sat_update(input cnt_t cnt, input logic taken);
        logic [1:0] val;
        val = cnt;
        if (taken) begin
            if (cnt != ST) begin
                val = val + 2'd1;
            end
        end else begin
            if (cnt != SNT) begin
                val = val - 2'd1;
            end
        end
        return cnt_t'(val);
    endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: array of 2-bit saturating counters.
// Asynchronous read port for same-cycle fetch lookup; one synchronous write
// port for EX-stage training. A read at the index being written returns the
// old counter; the new value is visible from the following cycle.
// Synchronous active-low reset returns every counter to weak not-taken.
module bht_table
    import pred_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [1:0]       wr_cnt
);

    cnt_t cnt_mem [0:N_ENT-1];

    // Counter storage: reset all entries to WNT, otherwise write on strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENT; i++) begin
                cnt_mem[i] <= WNT;
            end
        end else if (wr_en) begin
            cnt_mem[wr_idx] <= cnt_t'(wr_cnt);
        end
    end

    // Combinational read for the fetch-stage lookup.
    always_comb begin
        rd_cnt = cnt_mem[rd_idx];
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor: 2-bit counter BHT plus direct-mapped BTB.
// Optional feature macro: GSHARE_EN. When defined, the BHT is indexed by
// pc[IDX_W:1] XOR global history and the history register is trained from EX.
// When undefined the predictor is bimodal: history is held at zero and the
// pattern_* inputs are ignored.
//
// Lookup is purely combinational on pc_pc. Training interface from EX:
// br_inst_detect_ex is a single-cycle strobe with no back-pressure; every
// cycle it is high at a rising clk edge (and rst_n is high) commits exactly one
// update built from the other *_ex inputs sampled on that same edge. When it
// is low the *_ex inputs are don't-care and no state changes.
module branch_predictor
    import pred_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    // fetch-stage lookup
    input  logic [31:0]      pc_pc,
    input  logic             br_inst_detect_pc,
    output logic [1:0]       bht_pc,
    output logic [GHR_W-1:0] pattern_pc,
    output logic [31:0]      pred_pc_pc,
    output logic [TAG_W-1:0] tag_val,
    output logic             btb_hit_pc,
    output logic             pred_taken_pc,
    // EX-stage training
    input  logic [31:0]      pc_ex,
    input  logic             br_inst_detect_ex,
    input  logic             br_taken_ex,
    input  logic [1:0]       bht_ex,
    input  logic [GHR_W-1:0] pattern_old_ex,
    input  logic [GHR_W-1:0] pattern_new_ex,
    input  logic [31:0]      pred_pc_ex
);

    // Halfword-granular index so compressed instructions get their own slots.
    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [IDX_W-1:0] bht_rd_idx;
    logic [IDX_W-1:0] bht_wr_idx;
    logic [GHR_W-1:0] ghr;
    logic [1:0]       bht_wr_cnt;
    logic             unused_bits;

    assign pc_idx = pc_pc[IDX_W:1];
    assign ex_idx = pc_ex[IDX_W:1];

`ifdef GSHARE_EN
    // Global history register: takes the pipeline-built shifted history on each update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (br_inst_detect_ex) begin
            ghr <= pattern_new_ex;
        end
    end

    // Training index uses the history that was live when the branch was predicted.
    always_comb begin
        bht_rd_idx = pc_idx ^ ghr;
        bht_wr_idx = ex_idx ^ pattern_old_ex;
    end

    // Tag-aliased PC bits and the byte bit never select anything.
    assign unused_bits = ^{pc_pc[11:IDX_W+1], pc_pc[0], pc_ex[11:IDX_W+1], pc_ex[0]};
`else
    // Bimodal: history stays at zero, both ports index by PC alone.
    always_comb begin
        ghr        = '0;
        bht_rd_idx = pc_idx;
        bht_wr_idx = ex_idx;
    end

    // History inputs have no effect in the bimodal build.
    assign unused_bits = ^{pc_pc[11:IDX_W+1], pc_pc[0], pc_ex[11:IDX_W+1], pc_ex[0],
                           pattern_old_ex, pattern_new_ex};
`endif

    // New counter is derived from the value read at prediction time, not re-read.
    always_comb begin
        bht_wr_cnt = sat_update(cnt_t'(bht_ex), br_taken_ex);
    end

    bht_table u_bht (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_idx (bht_rd_idx),
        .rd_cnt (bht_pc),
        .wr_en  (br_inst_detect_ex),
        .wr_idx (bht_wr_idx),
        .wr_cnt (bht_wr_cnt)
    );

    // BTB storage, direct mapped on pc[IDX_W:1].
    logic             btb_valid  [0:N_ENT-1];
    logic [TAG_W-1:0] btb_tag    [0:N_ENT-1];
    logic [31:0]      btb_target [0:N_ENT-1];

    // BTB write: only taken branches allocate; not-taken leaves the entry alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENT; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
            end
        end else if (br_inst_detect_ex && br_taken_ex) begin
            btb_valid[ex_idx]  <= 1'b1;
            btb_tag[ex_idx]    <= pc_ex[31:12];
            btb_target[ex_idx] <= pred_pc_ex;
        end
    end

    // Lookup outputs: hit needs a valid entry whose tag matches pc[31:12].
    always_comb begin
        tag_val       = btb_tag[pc_idx];
        pred_pc_pc    = btb_target[pc_idx];
        btb_hit_pc    = btb_valid[pc_idx] && (btb_tag[pc_idx] == pc_pc[31:12]);
        pred_taken_pc = br_inst_detect_pc & btb_hit_pc & bht_pc[1];
        pattern_pc    = ghr;
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor. Builds in the default (bimodal)
// configuration; define GSHARE_EN to add the history-indexed scenario.
`timescale 1ns/1ps
module tb_branch_predictor;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [31:0] pc_pc = '0;
    logic        br_inst_detect_pc = 1'b0;
    logic [1:0]  bht_pc;
    logic [7:0]  pattern_pc;
    logic [31:0] pred_pc_pc;
    logic [19:0] tag_val;
    logic        btb_hit_pc;
    logic        pred_taken_pc;
    logic [31:0] pc_ex = '0;
    logic        br_inst_detect_ex = 1'b0;
    logic        br_taken_ex = 1'b0;
    logic [1:0]  bht_ex = '0;
    logic [7:0]  pattern_old_ex = '0;
    logic [7:0]  pattern_new_ex = '0;
    logic [31:0] pred_pc_ex = '0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pc_pc             (pc_pc),
        .br_inst_detect_pc (br_inst_detect_pc),
        .bht_pc            (bht_pc),
        .pattern_pc        (pattern_pc),
        .pred_pc_pc        (pred_pc_pc),
        .tag_val           (tag_val),
        .btb_hit_pc        (btb_hit_pc),
        .pred_taken_pc     (pred_taken_pc),
        .pc_ex             (pc_ex),
        .br_inst_detect_ex (br_inst_detect_ex),
        .br_taken_ex       (br_taken_ex),
        .bht_ex            (bht_ex),
        .pattern_old_ex    (pattern_old_ex),
        .pattern_new_ex    (pattern_new_ex),
        .pred_pc_ex        (pred_pc_ex)
    );

    // ---------------- scoreboard state ----------------
    int n_compared   = 0;
    int n_mismatched = 0;
    // {pattern(8), bht(2), hit(1), taken(1), tag(20), target(32)}
    logic [63:0] exp_q[$];

    // Reference model of predictor state.
    logic [1:0]  m_bht    [0:255];
    logic        m_valid  [0:255];
    logic [19:0] m_tag    [0:255];
    logic [31:0] m_target [0:255];
    logic [7:0]  m_ghr;

    function automatic logic [1:0] model_sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? 2'b11 : c + 2'd1;
        else   return (c == 2'b00) ? 2'b00 : c - 2'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            m_bht[i]    = 2'b01;
            m_valid[i]  = 1'b0;
            m_tag[i]    = '0;
            m_target[i] = '0;
        end
        m_ghr = '0;
    endtask

    function automatic logic [7:0] model_rd_idx(input logic [31:0] pc);
`ifdef GSHARE_EN
        return pc[8:1] ^ m_ghr;
`else
        return pc[8:1];
`endif
    endfunction

    task automatic model_apply(input logic [31:0] pc, input logic taken, input logic [1:0] cnt,
                               input logic [7:0] p_old, input logic [7:0] p_new,
                               input logic [31:0] target);
        logic [7:0] bidx;
        logic [7:0] tidx;
        tidx = pc[8:1];
`ifdef GSHARE_EN
        bidx  = tidx ^ p_old;
        m_ghr = p_new;
`else
        bidx = tidx;
`endif
        m_bht[bidx] = model_sat(cnt, taken);
        if (taken) begin
            m_valid[tidx]  = 1'b1;
            m_tag[tidx]    = pc[31:12];
            m_target[tidx] = target;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_expect(input logic [31:0] pc, input logic det);
        logic [7:0]  tidx;
        logic [1:0]  cnt;
        logic        hit;
        logic [7:0]  pat;
        tidx = pc[8:1];
        cnt  = m_bht[model_rd_idx(pc)];
        hit  = m_valid[tidx] && (m_tag[tidx] == pc[31:12]);
`ifdef GSHARE_EN
        pat = m_ghr;
`else
        pat = 8'h00;
`endif
        exp_q.push_back({pat, cnt, hit, det & hit & cnt[1], m_tag[tidx], m_target[tidx]});
    endtask

    task automatic compare_lookup(input string name);
        logic [63:0] act;
        logic [63:0] exp;
        act = {pattern_pc, bht_pc, btb_hit_pc, pred_taken_pc, tag_val, pred_pc_pc};
        n_compared++;
        if (exp_q.size() == 0) begin
            n_mismatched++;
            $display("FAIL %s: no expected entry queued, got %h", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_mismatched++;
                $display("FAIL %s: pc=%h got {pat,bht,hit,tkn,tag,tgt}=%h expected %h",
                         name, pc_pc, act, exp);
            end
        end
    endtask

    task automatic lookup(input string name, input logic [31:0] pc, input logic det);
        @(negedge clk);
        pc_pc             = pc;
        br_inst_detect_pc = det;
        push_expect(pc, det);
        #1;
        compare_lookup(name);
    endtask

    task automatic drive_ex(input logic det, input logic [31:0] pc, input logic taken,
                            input logic [1:0] cnt, input logic [7:0] p_old,
                            input logic [7:0] p_new, input logic [31:0] target);
        br_inst_detect_ex = det;
        pc_ex             = pc;
        br_taken_ex       = taken;
        bht_ex            = cnt;
        pattern_old_ex    = p_old;
        pattern_new_ex    = p_new;
        pred_pc_ex        = target;
    endtask

    task automatic update(input logic [31:0] pc, input logic taken, input logic [1:0] cnt,
                          input logic [7:0] p_old, input logic [7:0] p_new,
                          input logic [31:0] target);
        @(negedge clk);
        drive_ex(1'b1, pc, taken, cnt, p_old, p_new, target);
        @(posedge clk);
        #1;
        model_apply(pc, taken, cnt, p_old, p_new, target);
        br_inst_detect_ex = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        lookup("reset_lookup_100", 32'h100, 1'b1);
        n_compared++;
        if (bht_pc !== 2'b01 || btb_hit_pc !== 1'b0 || pred_taken_pc !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_const: bht=%b hit=%b tkn=%b expected 01 0 0",
                     bht_pc, btb_hit_pc, pred_taken_pc);
        end
        n_compared++;
        if (pred_pc_pc !== 32'h0 || tag_val !== 20'h0 || pattern_pc !== 8'h0) begin
            n_mismatched++;
            $display("FAIL reset_zero: tgt=%h tag=%h pat=%h expected all 0",
                     pred_pc_pc, tag_val, pattern_pc);
        end
        lookup("reset_lookup_0", 32'h0, 1'b1);
        lookup("reset_lookup_1fe", 32'hFFFF_F1FE, 1'b1);
    endtask

    task automatic test_train();
        update(32'h100, 1'b1, 2'b01, 8'h00, 8'h00, 32'h200);
        lookup("train_one", 32'h100, 1'b1);
        update(32'h100, 1'b1, 2'b10, 8'h00, 8'h00, 32'h200);
        lookup("train_two", 32'h100, 1'b1);
        n_compared++;
        if (bht_pc !== 2'b11 || tag_val !== 20'h0 || btb_hit_pc !== 1'b1 ||
            pred_pc_pc !== 32'h200 || pred_taken_pc !== 1'b1) begin
            n_mismatched++;
            $display("FAIL train_const: bht=%b tag=%h hit=%b tgt=%h tkn=%b expected 11 0 1 200 1",
                     bht_pc, tag_val, btb_hit_pc, pred_pc_pc, pred_taken_pc);
        end
        lookup("train_not_branch", 32'h100, 1'b0);
        n_compared++;
        if (pred_taken_pc !== 1'b0) begin
            n_mismatched++;
            $display("FAIL train_no_detect: tkn=%b expected 0", pred_taken_pc);
        end
    endtask

    task automatic test_alias();
        lookup("alias_1100", 32'h1100, 1'b1);
        n_compared++;
        if (tag_val !== 20'h0 || btb_hit_pc !== 1'b0 || pred_taken_pc !== 1'b0) begin
            n_mismatched++;
            $display("FAIL alias_const: tag=%h hit=%b tkn=%b expected 0 0 0",
                     tag_val, btb_hit_pc, pred_taken_pc);
        end
    endtask

    task automatic test_saturation();
        update(32'h100, 1'b1, 2'b11, 8'h00, 8'h00, 32'h200);
        lookup("sat_top", 32'h100, 1'b1);
        n_compared++;
        if (bht_pc !== 2'b11) begin
            n_mismatched++;
            $display("FAIL sat_top_const: bht=%b expected 11", bht_pc);
        end
        update(32'h100, 1'b0, 2'b00, 8'h00, 8'h00, 32'h300);
        lookup("sat_bottom", 32'h100, 1'b1);
        n_compared++;
        if (bht_pc !== 2'b00 || pred_pc_pc !== 32'h200 || btb_hit_pc !== 1'b1) begin
            n_mismatched++;
            $display("FAIL sat_bottom_const: bht=%b tgt=%h hit=%b expected 00 200 1",
                     bht_pc, pred_pc_pc, btb_hit_pc);
        end
        update(32'h100, 1'b0, 2'b10, 8'h00, 8'h00, 32'h300);
        lookup("sat_down", 32'h100, 1'b1);
        n_compared++;
        if (bht_pc !== 2'b01 || pred_taken_pc !== 1'b0) begin
            n_mismatched++;
            $display("FAIL sat_down_const: bht=%b tkn=%b expected 01 0", bht_pc, pred_taken_pc);
        end
    endtask

    task automatic test_no_update_and_rdw();
        // Strobe low with everything else driven: nothing may change.
        @(negedge clk);
        drive_ex(1'b0, 32'h100, 1'b1, 2'b11, 8'h00, 8'h55, 32'h400);
        repeat (2) @(posedge clk);
        #1;
        lookup("no_update", 32'h100, 1'b1);
        n_compared++;
        if (bht_pc !== 2'b01 || pred_pc_pc !== 32'h200 || pattern_pc !== 8'h00) begin
            n_mismatched++;
            $display("FAIL no_update_const: bht=%b tgt=%h pat=%h expected 01 200 00",
                     bht_pc, pred_pc_pc, pattern_pc);
        end
        // Read the index being written in the same cycle: old contents.
        @(negedge clk);
        drive_ex(1'b1, 32'h100, 1'b1, 2'b01, 8'h00, 8'h00, 32'h500);
        pc_pc             = 32'h100;
        br_inst_detect_pc = 1'b1;
        push_expect(32'h100, 1'b1);
        #1;
        compare_lookup("rdw_old");
        n_compared++;
        if (bht_pc !== 2'b01 || pred_pc_pc !== 32'h200) begin
            n_mismatched++;
            $display("FAIL rdw_old_const: bht=%b tgt=%h expected 01 200", bht_pc, pred_pc_pc);
        end
        @(posedge clk);
        #1;
        model_apply(32'h100, 1'b1, 2'b01, 8'h00, 8'h00, 32'h500);
        br_inst_detect_ex = 1'b0;
        lookup("rdw_new", 32'h100, 1'b1);
        n_compared++;
        if (bht_pc !== 2'b10 || pred_pc_pc !== 32'h500) begin
            n_mismatched++;
            $display("FAIL rdw_new_const: bht=%b tgt=%h expected 10 500", bht_pc, pred_pc_pc);
        end
    endtask

    task automatic test_mid_reset();
        // Reset asserted together with an update strobe: reset wins.
        @(negedge clk);
        rst_n = 1'b0;
        drive_ex(1'b1, 32'h100, 1'b1, 2'b10, 8'h00, 8'h00, 32'h600);
        repeat (2) @(negedge clk);
        br_inst_detect_ex = 1'b0;
        rst_n             = 1'b1;
        model_reset();
        lookup("mid_reset", 32'h100, 1'b1);
        n_compared++;
        if (bht_pc !== 2'b01 || btb_hit_pc !== 1'b0 || pred_pc_pc !== 32'h0) begin
            n_mismatched++;
            $display("FAIL mid_reset_const: bht=%b hit=%b tgt=%h expected 01 0 0",
                     bht_pc, btb_hit_pc, pred_pc_pc);
        end
    endtask

`ifdef GSHARE_EN
    task automatic test_gshare();
        do_reset();
        update(32'h100, 1'b1, 2'b01, 8'h00, 8'h01, 32'h200);
        lookup("gshare_hist", 32'h100, 1'b1);
        n_compared++;
        if (pattern_pc !== 8'h01 || bht_pc !== 2'b01) begin
            n_mismatched++;
            $display("FAIL gshare_hist_const: pat=%h bht=%b expected 01 01", pattern_pc, bht_pc);
        end
        lookup("gshare_trained", 32'h102, 1'b1);
        n_compared++;
        if (bht_pc !== 2'b10) begin
            n_mismatched++;
            $display("FAIL gshare_trained_const: bht=%b expected 10", bht_pc);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [31:0] pc;
        logic [19:0] tag;
        logic        taken;
        logic [1:0]  cnt;
        logic [7:0]  hist;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0:       tag = 20'h00000;
                1:       tag = 20'h00001;
                default: tag = 20'h12345;
            endcase
            pc    = {tag, 3'($urandom_range(0, 7)), 8'($urandom_range(8'h80, 8'h87)), 1'b0};
            taken = 1'($urandom_range(0, 1));
            lookup("b2b_lookup", pc, 1'($urandom_range(0, 1)));
            cnt  = m_bht[model_rd_idx(pc)];
            hist = m_ghr;
            update(pc, taken, cnt, hist, {hist[6:0], taken}, $urandom);
        end
        lookup("b2b_final", 32'h100, 1'b1);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        test_reset();
        test_train();
        test_alias();
        test_saturation();
        test_no_update_and_rdw();
        test_mid_reset();
`ifdef GSHARE_EN
        test_gshare();
`endif
        test_back_to_back();
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
